// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the ESP32-side controller and the traffic phase sequencer.
// The master drives the requests; the slave (sequencer) drives the decoder outputs.
interface traffic_phase_sequencer_if;
  logic       flash_req;
  logic       ext_enable;
  logic       ext_valid;
  logic [3:0] ext_code;
  logic       ext_dest;
  logic [3:0] ciclo;
  logic       destello;
  logic [1:0] mode;
  logic       fault;

  modport master (
    output flash_req, ext_enable, ext_valid, ext_code, ext_dest,
    input  ciclo, destello, mode, fault
  );

  modport slave (
    input  flash_req, ext_enable, ext_valid, ext_code, ext_dest,
    output ciclo, destello, mode, fault
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Fixed-time 4-phase traffic plan with amber-flash fallback and ESP32 remote override.
// Produces the registered cycle code / flash bit consumed by the light decoder.
module traffic_phase_sequencer #(
  parameter int TICK_DIV      = 27_000_000,
  parameter int GREEN_S       = 20,
  parameter int AMBER_S       = 3,
  parameter int FLASH_GREEN_S = 3,
  parameter int STARTUP_S     = 5,
  parameter int WDT_S         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_phase_sequencer_if.slave    bus
);

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  L_PMAX   = PW'(TICK_DIV - 1);
  localparam logic [7:0]     L_GREEN  = 8'(GREEN_S);
  localparam logic [7:0]     L_AMBER  = 8'(AMBER_S);
  localparam logic [7:0]     L_FGREEN = 8'(FLASH_GREEN_S);
  localparam logic [7:0]     L_START  = 8'(STARTUP_S);
  localparam logic [7:0]     L_WDT    = 8'(WDT_S);

  typedef enum logic [1:0] {
    S_FLASH  = 2'd0,
    S_GREEN  = 2'd1,
    S_AMBER  = 2'd2,
    S_REMOTE = 2'd3
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_phase, w_phase_nx;
  logic [7:0]    r_timer, w_timer_nx;
  logic [7:0]    r_wdt, w_wdt_nx;
  logic [3:0]    r_code, w_code_nx;
  logic          r_rdest, w_rdest_nx;
  logic          r_fault, w_fault_nx;
  logic          r_blink, w_blink_nx;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_ciclo, w_ciclo_nx;
  logic          r_destello, w_destello_nx;
  logic [1:0]    r_mode, w_mode_nx;
  logic          w_tick, w_strobe, w_accept, w_wdt_exp;

  function automatic logic f_code_legal(input logic [3:0] code);
    return code <= 4'd8;
  endfunction

  // A green request may only replace a different green once the light has passed amber/flash.
  function automatic logic f_green_conflict(input logic [3:0] code, input logic [3:0] cur);
    return code[0] & cur[0] & (code != cur);
  endfunction

  function automatic logic [1:0] f_phase_of(input logic [3:0] code);
    return 2'((code - 4'd1) >> 1);
  endfunction

  assign w_tick    = (r_presc == L_PMAX);
  assign w_strobe  = bus.ext_enable & bus.ext_valid;
  assign w_accept  = w_strobe & f_code_legal(bus.ext_code)
                   & ~f_green_conflict(bus.ext_code, r_ciclo);
  assign w_wdt_exp = (r_state == S_REMOTE) & w_tick & (r_wdt >= (L_WDT - 8'd1));

  // Free-running prescaler; state changes never disturb it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Next-state selection in priority order, then next-output decode.
  always_comb begin
    w_state_nx    = r_state;
    w_phase_nx    = r_phase;
    w_timer_nx    = r_timer;
    w_wdt_nx      = r_wdt;
    w_code_nx     = r_code;
    w_rdest_nx    = r_rdest;
    w_fault_nx    = r_fault;
    w_blink_nx    = r_blink ^ w_tick;
    w_ciclo_nx    = 4'd0;
    w_destello_nx = 1'b0;
    w_mode_nx     = 2'b00;

    if (bus.flash_req) begin
      w_state_nx = S_FLASH;
      w_timer_nx = L_START;
    end else if (w_wdt_exp) begin
      w_fault_nx = 1'b1;
      w_state_nx = S_FLASH;
      w_timer_nx = L_START;
    end else if ((r_state == S_REMOTE) && !bus.ext_enable) begin
      if (r_code == 4'd0) begin
        w_state_nx = S_FLASH;
        w_timer_nx = L_START;
      end else begin
        w_state_nx = S_AMBER;
        w_phase_nx = f_phase_of(r_code);
        w_timer_nx = L_AMBER;
      end
    end else if (w_accept) begin
      w_state_nx = S_REMOTE;
      w_code_nx  = bus.ext_code;
      w_rdest_nx = bus.ext_dest;
      w_wdt_nx   = 8'd0;
    end else begin
      w_fault_nx = r_fault | w_strobe;
      if (r_state == S_REMOTE) begin
        w_wdt_nx = w_tick ? (r_wdt + 8'd1) : r_wdt;
      end else if (w_tick && (r_timer == 8'd1)) begin
        case (r_state)
          S_FLASH: begin
            w_state_nx = S_GREEN;
            w_phase_nx = 2'd0;
            w_timer_nx = L_GREEN;
          end
          S_GREEN: begin
            w_state_nx = S_AMBER;
            w_timer_nx = L_AMBER;
          end
          S_AMBER: begin
            w_state_nx = S_GREEN;
            w_phase_nx = r_phase + 2'd1;
            w_timer_nx = L_GREEN;
          end
          default: begin
            w_state_nx = S_FLASH;
            w_timer_nx = L_START;
          end
        endcase
      end else if (w_tick) begin
        w_timer_nx = r_timer - 8'd1;
      end else begin
        w_timer_nx = r_timer;
      end
    end

    case (w_state_nx)
      S_FLASH: begin
        w_ciclo_nx    = 4'd0;
        w_destello_nx = w_blink_nx;
        w_mode_nx     = 2'b00;
      end
      S_GREEN: begin
        w_ciclo_nx    = 4'({w_phase_nx, 1'b1});
        w_destello_nx = (w_timer_nx <= L_FGREEN) ? w_blink_nx : 1'b0;
        w_mode_nx     = 2'b01;
      end
      S_AMBER: begin
        w_ciclo_nx    = 4'({w_phase_nx, 1'b0}) + 4'd2;
        w_destello_nx = 1'b0;
        w_mode_nx     = 2'b01;
      end
      S_REMOTE: begin
        w_ciclo_nx    = w_code_nx;
        w_destello_nx = ((w_code_nx != 4'd0) && !w_code_nx[0]) ? 1'b0 : (w_rdest_nx & w_blink_nx);
        w_mode_nx     = 2'b10;
      end
      default: begin
        w_ciclo_nx    = 4'd0;
        w_destello_nx = 1'b0;
        w_mode_nx     = 2'b00;
      end
    endcase
  end

  // State and registered decoder outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_FLASH;
      r_phase    <= 2'd0;
      r_timer    <= L_START;
      r_wdt      <= 8'd0;
      r_code     <= 4'd0;
      r_rdest    <= 1'b0;
      r_fault    <= 1'b0;
      r_blink    <= 1'b0;
      r_ciclo    <= 4'd0;
      r_destello <= 1'b0;
      r_mode     <= 2'b00;
    end else begin
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_timer    <= w_timer_nx;
      r_wdt      <= w_wdt_nx;
      r_code     <= w_code_nx;
      r_rdest    <= w_rdest_nx;
      r_fault    <= w_fault_nx;
      r_blink    <= w_blink_nx;
      r_ciclo    <= w_ciclo_nx;
      r_destello <= w_destello_nx;
      r_mode     <= w_mode_nx;
    end
  end

  assign bus.ciclo    = r_ciclo;
  assign bus.destello = r_destello;
  assign bus.mode     = r_mode;
  assign bus.fault    = r_fault;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench: a plan-level reference model predicts every cycle's decoder outputs.
module tb_traffic_phase_sequencer;
  localparam int TD = 4, GS = 4, AS = 2, FG = 1, ST = 2, WD = 3;

  typedef struct packed {
    logic [3:0] ciclo;
    logic       destello;
    logic [1:0] mode;
    logic       fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  traffic_phase_sequencer_if bus ();

  traffic_phase_sequencer #(
    .TICK_DIV(TD), .GREEN_S(GS), .AMBER_S(AS),
    .FLASH_GREEN_S(FG), .STARTUP_S(ST), .WDT_S(WD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: mode 0 flash, 1 local plan, 2 remote. Local plan is a list of
  // 8 steps; step s shows code s+1 and lasts GS ticks (even s) or AS ticks (odd s).
  int m_mode, m_step, m_left, m_presc, m_silent, m_rcode, m_ciclo;
  bit m_blink, m_fault, m_rdest;

  task automatic model_step(input logic r, input logic fr, input logic en, input logic v,
                            input logic [3:0] c, input logic d);
    bit   tick;
    exp_t e;
    if (!r) begin
      m_mode = 0; m_step = 0; m_left = ST; m_presc = 0; m_silent = 0;
      m_rcode = 0; m_blink = 0; m_fault = 0; m_rdest = 0;
    end else begin
      tick    = (m_presc == TD - 1);
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) m_blink = !m_blink;
      if (fr) begin
        m_mode = 0; m_left = ST;
      end else if (m_mode == 2 && tick && m_silent + 1 >= WD) begin
        m_fault = 1; m_mode = 0; m_left = ST;
      end else if (m_mode == 2 && !en) begin
        if (m_rcode == 0) begin
          m_mode = 0; m_left = ST;
        end else begin
          m_mode = 1; m_left = AS;
          m_step = (m_rcode % 2 == 1) ? m_rcode : m_rcode - 1;
        end
      end else if (en && v && c <= 8 && !(c % 2 == 1 && m_ciclo % 2 == 1 && c != m_ciclo)) begin
        m_mode = 2; m_rcode = c; m_rdest = d; m_silent = 0;
      end else begin
        if (en && v) m_fault = 1;
        if (m_mode == 2) begin
          if (tick) m_silent++;
        end else if (tick) begin
          if (m_left == 1) begin
            if (m_mode == 0) begin
              m_mode = 1; m_step = 0;
            end else begin
              m_step = (m_step + 1) % 8;
            end
            m_left = (m_step % 2 == 0) ? GS : AS;
          end else begin
            m_left--;
          end
        end
      end
    end
    if (!r) begin
      e = '0;
    end else if (m_mode == 0) begin
      e.ciclo = 4'd0; e.destello = m_blink; e.mode = 2'd0; e.fault = m_fault;
    end else if (m_mode == 1) begin
      e.ciclo    = 4'(m_step + 1);
      e.destello = (m_step % 2 == 0 && m_left <= FG) ? m_blink : 1'b0;
      e.mode     = 2'd1; e.fault = m_fault;
    end else begin
      e.ciclo    = 4'(m_rcode);
      e.destello = (m_rcode != 0 && m_rcode % 2 == 0) ? 1'b0 : (m_rdest & m_blink);
      e.mode     = 2'd2; e.fault = m_fault;
    end
    m_ciclo = int'(e.ciclo);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic r, input logic fr, input logic en, input logic v,
                       input logic [3:0] c, input logic d);
    @(negedge clk);
    rst = r; bus.flash_req = fr; bus.ext_enable = en; bus.ext_valid = v;
    bus.ext_code = c; bus.ext_dest = d;
    model_step(r, fr, en, v, c, d);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) apply(1'b1, 1'b0, en, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic strobe(input logic [3:0] c, input logic d);
    apply(1'b1, 1'b0, 1'b1, 1'b1, c, d);
  endtask

  // Monitor: outputs are valid every cycle, so each post-edge sample consumes one entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.ciclo !== e.ciclo || bus.destello !== e.destello ||
            bus.mode !== e.mode || bus.fault !== e.fault) begin
          n_err++;
          $display("FAIL outputs @%0t: got ciclo=%0d destello=%0b mode=%0d fault=%0b, expected ciclo=%0d destello=%0b mode=%0d fault=%0b",
                   $time, bus.ciclo, bus.destello, bus.mode, bus.fault,
                   e.ciclo, e.destello, e.mode, e.fault);
        end
      end
    end
  end

  initial begin
    logic fr, en, v, d, r;
    logic [3:0] c;
    rst = 1'b0; bus.flash_req = 1'b0; bus.ext_enable = 1'b0; bus.ext_valid = 1'b0;
    bus.ext_code = 4'd0; bus.ext_dest = 1'b0;

    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(130, 1'b0);
    // flash request mid-plan, then restart
    idle(20, 1'b0);
    repeat (3) apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(40, 1'b0);
    // remote entry then silence -> watchdog
    strobe(4'd5, 1'b1);
    idle(20, 1'b1);
    // green-to-green rules, illegal code, enable drop at green 4
    strobe(4'd1, 1'b1); idle(2, 1'b1);
    strobe(4'd3, 1'b0); idle(2, 1'b1);
    strobe(4'd2, 1'b0); idle(2, 1'b1);
    strobe(4'd3, 1'b1); idle(2, 1'b1);
    strobe(4'd12, 1'b0); idle(2, 1'b1);
    strobe(4'd4, 1'b0); idle(2, 1'b1);
    strobe(4'd7, 1'b1); idle(2, 1'b1);
    idle(30, 1'b0);
    // reset mid-green
    apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(30, 1'b0);
    strobe(4'd0, 1'b1); idle(3, 1'b1);
    idle(15, 1'b0);

    fr = 1'b0; en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fr) fr = ($urandom_range(3) != 0);
      else    fr = ($urandom_range(199) == 0);
      if ($urandom_range(39) == 0) en = ~en;
      v = ($urandom_range(5) == 0);
      c = ($urandom_range(9) == 0) ? 4'($urandom_range(15, 9)) : 4'($urandom_range(8));
      d = 1'($urandom_range(1));
      r = ($urandom_range(599) != 0);
      apply(r, fr, en, v, c, d);
    end
    idle(4, 1'b0);

    @(posedge clk); #4;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
